// File: rtl/wb_demux_buf_pkg.sv
// rtl/wb_demux_buf_pkg.sv - shared constants, request type and one-hot decode for wb_demux_buf
package wb_pkg;

    localparam int NREG     = 32;
    localparam int DW       = 64;
    localparam int AW       = 5;
    localparam int ZERO_REG = 31;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_req_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } fifo_state_t;

    // XZR and indices beyond the register file decode to no enable at all
    function automatic logic [NREG-1:0] onehot_dec(input logic [AW-1:0] addr);
        logic [NREG-1:0] v;
        v = '0;
        for (int i = 0; i < NREG; i++) begin
            if ((int'(addr) == i) && (i != ZERO_REG)) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/wb_demux_buf_dec_onehot.sv
// rtl/wb_demux_buf_dec_onehot.sv - gated AW-to-NREG one-hot decoder
module dec_onehot
    import wb_pkg::*;
(
    input  logic            en,
    input  logic [AW-1:0]   addr,
    output logic [NREG-1:0] onehot
);

    assign onehot = en ? onehot_dec(addr) : '0;

endmodule

// File: rtl/wb_demux_buf.sv
// rtl/wb_demux_buf.sv - writeback demux with 2-entry write buffer; WB_DEMUX_BYPASS_EN enables zero-latency bypass
module wb_demux_buf
    import wb_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [AW-1:0]   in_addr,
    input  logic [DW-1:0]   in_data,
    input  logic            rf_hold,
    output logic [NREG-1:0] out_wr_en,
    output logic [DW-1:0]   out_data,
    output logic [NREG-1:0] pend_mask,
    output logic            overflow_err
);

    fifo_state_t     state, state_nxt;
    logic            head, tail;
    wb_req_t         mem [2];
    logic            ready_q;
    logic            push, pop, byp;
    logic            dec_en;
    logic [AW-1:0]   dec_addr;
    logic [NREG-1:0] pend [2];
    logic [1:0]      ent_vld;
    wb_req_t         head_req;

    assign head_req = mem[head];
    assign in_ready = ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (push) state_nxt = ONE;
            ONE: begin
                if (push && !pop)      state_nxt = TWO;
                else if (!push && pop) state_nxt = EMPTY;
            end
            TWO:     if (pop) state_nxt = ONE;
            default: state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        pop      = (state != EMPTY) && !rf_hold;
        byp      = 1'b0;
`ifdef WB_DEMUX_BYPASS_EN
        byp      = (state == EMPTY) && in_valid && ready_q && !rf_hold;
`endif
        push     = in_valid && ready_q && !byp;
        dec_en   = pop;
        dec_addr = head_req.addr;
        out_data = (state != EMPTY) ? head_req.data : '0;
        if (byp) begin
            dec_en   = 1'b1;
            dec_addr = in_addr;
            out_data = in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head         <= 1'b0;
            tail         <= 1'b0;
            mem[0]       <= '0;
            mem[1]       <= '0;
            ready_q      <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            if (push) begin
                mem[tail] <= '{addr: in_addr, data: in_data};
                tail      <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
            ready_q <= (state_nxt != TWO);
            if (in_valid && !ready_q) begin
                overflow_err <= 1'b1;
            end
        end
    end

    dec_onehot u_dec_wr (
        .en     (dec_en),
        .addr   (dec_addr),
        .onehot (out_wr_en)
    );

    // An entry is live when the buffer is full, or when it is the head of a single-entry buffer
    for (genvar g = 0; g < 2; g++) begin : g_pend
        assign ent_vld[g] = (state == TWO) || ((state == ONE) && (head == 1'(g)));

        dec_onehot u_dec_pend (
            .en     (ent_vld[g]),
            .addr   (mem[g].addr),
            .onehot (pend[g])
        );
    end

    assign pend_mask = pend[0] | pend[1];

endmodule
